// File: rtl/rv32_instr_encoder.sv
// rv32_instr_encoder: two-stage valid/ready RV32I instruction packer that checks the
// immediate against the target format and counts good and bad words delivered.
`timescale 1ns/1ps
module rv32_instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [1:0]       out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_ISH = 3'd2,
        FMT_S   = 3'd3,
        FMT_B   = 3'd4,
        FMT_U   = 3'd5,
        FMT_J   = 3'd6,
        FMT_X   = 3'd7
    } fmt_e;

    localparam logic [1:0]  ERR_OK    = 2'd0;
    localparam logic [1:0]  ERR_RANGE = 2'd1;
    localparam logic [1:0]  ERR_ALIGN = 2'd2;
    localparam logic [1:0]  ERR_OPC   = 2'd3;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    // True when imm[31:lsb] are all equal, i.e. the value sign-extends from bit lsb.
    function automatic logic sext_fits(input logic [31:0] imm, input int lsb);
        logic [31:0] sh;
        sh = 32'($signed(imm) >>> lsb);
        return (sh == 32'h0000_0000) || (sh == 32'hFFFF_FFFF);
    endfunction

    function automatic fmt_e decode_fmt(input logic [6:0] op, input logic [2:0] f3);
        fmt_e f;
        case (op)
            7'b0110011: f = FMT_R;
            7'b0010011: f = ((f3 == 3'b001) || (f3 == 3'b101)) ? FMT_ISH : FMT_I;
            7'b0000011: f = FMT_I;
            7'b1100111: f = FMT_I;
            7'b0100011: f = FMT_S;
            7'b1100011: f = FMT_B;
            7'b0110111: f = FMT_U;
            7'b0010111: f = FMT_U;
            7'b1101111: f = FMT_J;
            default:    f = FMT_X;
        endcase
        return f;
    endfunction

    // Illegal opcode outranks misalignment, which outranks an out-of-range value.
    function automatic logic [1:0] imm_err(input fmt_e f, input logic [31:0] imm);
        logic [1:0] e;
        case (f)
            FMT_R:        e = ERR_OK;
            FMT_I, FMT_S: e = sext_fits(imm, 11) ? ERR_OK : ERR_RANGE;
            FMT_ISH:      e = (imm[31:5] == 27'd0) ? ERR_OK : ERR_RANGE;
            FMT_B: begin
                if (imm[0]) begin
                    e = ERR_ALIGN;
                end else begin
                    e = sext_fits(imm, 12) ? ERR_OK : ERR_RANGE;
                end
            end
            FMT_J: begin
                if (imm[0]) begin
                    e = ERR_ALIGN;
                end else begin
                    e = sext_fits(imm, 20) ? ERR_OK : ERR_RANGE;
                end
            end
            FMT_U:        e = (imm[11:0] == 12'd0) ? ERR_OK : ERR_ALIGN;
            default:      e = ERR_OPC;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] pack_word(
        input fmt_e        f,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        case (f)
            FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
            FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
            FMT_ISH: w = {f7, imm[4:0], rs1, f3, rd, op};
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   w = {imm[31:12], rd, op};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (&c) begin
            r = c;
        end else begin
            r = c + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    logic             s1_valid_q;
    logic [6:0]       s1_op_q;
    logic [4:0]       s1_rd_q;
    logic [4:0]       s1_rs1_q;
    logic [4:0]       s1_rs2_q;
    logic [2:0]       s1_f3_q;
    logic [6:0]       s1_f7_q;
    logic [31:0]      s1_imm_q;
    fmt_e             s1_fmt_q, s1_fmt_d;
    logic [1:0]       s1_err_q, s1_err_d;
    logic             s2_valid_q;
    logic [31:0]      s2_instr_q, s2_instr_d;
    logic [1:0]       s2_err_q;
    logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             s1_adv_s;
    logic             out_xfer_s;

    assign s1_adv_s   = ~s2_valid_q | out_ready;
    assign in_ready   = reset_n & (~s1_valid_q | s1_adv_s);
    assign out_xfer_s = s2_valid_q & out_ready;

    // Decode, check and pack; counter next-state for the current output transfer.
    always_comb begin
        s1_fmt_d   = decode_fmt(in_opcode, in_funct3);
        s1_err_d   = imm_err(s1_fmt_d, in_imm);
        s2_instr_d = NOP_WORD;
        enc_cnt_d  = enc_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (s1_err_q == ERR_OK) begin
            s2_instr_d = pack_word(s1_fmt_q, s1_op_q, s1_rd_q, s1_rs1_q, s1_rs2_q,
                                   s1_f3_q, s1_f7_q, s1_imm_q);
        end else begin
            s2_instr_d = NOP_WORD;
        end
        if (out_xfer_s && (s2_err_q == ERR_OK)) begin
            enc_cnt_d = sat_inc(enc_cnt_q);
        end else if (out_xfer_s) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end else begin
            enc_cnt_d = enc_cnt_q;
        end
    end

    // Pipeline stages and counters; a stage only loads data when it captures a valid entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 7'd0;
            s1_rd_q    <= 5'd0;
            s1_rs1_q   <= 5'd0;
            s1_rs2_q   <= 5'd0;
            s1_f3_q    <= 3'd0;
            s1_f7_q    <= 7'd0;
            s1_imm_q   <= 32'd0;
            s1_fmt_q   <= FMT_R;
            s1_err_q   <= ERR_OK;
            s2_valid_q <= 1'b0;
            s2_instr_q <= 32'd0;
            s2_err_q   <= ERR_OK;
            enc_cnt_q  <= {CNT_W{1'b0}};
            err_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_op_q  <= in_opcode;
                    s1_rd_q  <= in_rd;
                    s1_rs1_q <= in_rs1;
                    s1_rs2_q <= in_rs2;
                    s1_f3_q  <= in_funct3;
                    s1_f7_q  <= in_funct7;
                    s1_imm_q <= in_imm;
                    s1_fmt_q <= s1_fmt_d;
                    s1_err_q <= s1_err_d;
                end
            end
            if (s1_adv_s) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_instr_q <= s2_instr_d;
                    s2_err_q   <= s1_err_q;
                end
            end
            enc_cnt_q <= enc_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_instr = s2_instr_q;
    assign out_err   = s2_err_q;
    assign enc_count = enc_cnt_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Randomized and directed bench for rv32_instr_encoder with an arithmetic reference model
// and an in-order scoreboard; a second CNT_W=2 instance exercises counter saturation.
`timescale 1ns/1ps
module tb_rv32_instr_encoder;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        out_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;

    logic        in_ready, out_valid;
    logic [31:0] out_instr;
    logic [1:0]  out_err;
    logic [15:0] enc_count, err_count;

    logic        in_ready_s, out_valid_s;
    logic [31:0] out_instr_s;
    logic [1:0]  out_err_s;
    logic [1:0]  enc_count_s, err_count_s;

    rv32_instr_encoder #(.CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
    );

    rv32_instr_encoder #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_instr(out_instr_s),
        .out_err(out_err_s), .enc_count(enc_count_s), .err_count(err_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [33:0] sb_q[$];
    int          sb_cyc[$];
    int          exp_enc  = 0;
    int          exp_err  = 0;
    bit          acc_flag = 1'b0;
    bit          deliv_flag = 1'b0;
    bit          hold_prev = 1'b0;
    logic [31:0] prev_instr = 32'd0;
    logic [31:0] last_instr = 32'd0;
    logic [1:0]  last_err = 2'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: encoding rules expressed as plain shifts/masks and signed ranges.
    function automatic logic [33:0] model(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] imm);
        longint      s;
        logic [31:0] w, base, rdp;
        logic [1:0]  e;
        s    = longint'($signed(imm));
        base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        rdp  = 32'(rd) << 7;
        e    = 2'd0;
        w    = 32'd0;
        case (op)
            7'h33: w = (32'(f7) << 25) | (32'(rs2) << 20) | base | rdp;
            7'h13, 7'h03, 7'h67: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    if (imm > 32'd31) e = 2'd1;
                    else w = (32'(f7) << 25) | (imm << 20) | base | rdp;
                end else begin
                    if (s < -2048 || s > 2047) e = 2'd1;
                    else w = ((imm & 32'hFFF) << 20) | base | rdp;
                end
            end
            7'h23: begin
                if (s < -2048 || s > 2047) e = 2'd1;
                else w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base
                         | ((imm & 32'h1F) << 7);
            end
            7'h63: begin
                if ((imm & 32'd1) != 32'd0) e = 2'd2;
                else if (s < -4096 || s > 4095) e = 2'd1;
                else w = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                         | (32'(rs2) << 20) | base | (((imm >> 1) & 32'hF) << 8)
                         | (((imm >> 11) & 32'd1) << 7);
            end
            7'h37, 7'h17: begin
                if ((imm % 32'd4096) != 32'd0) e = 2'd2;
                else w = imm | rdp | 32'(op);
            end
            7'h6F: begin
                if ((imm & 32'd1) != 32'd0) e = 2'd2;
                else if (s < -(64'sd1 <<< 20) || s >= (64'sd1 <<< 20)) e = 2'd1;
                else w = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                         | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                         | rdp | 32'(op);
            end
            default: e = 2'd3;
        endcase
        if (e != 2'd0) w = 32'h0000_0013;
        return {e, w};
    endfunction

    // One clock: check the cycle at the falling edge, update the scoreboard, advance.
    task automatic cycle();
        logic [33:0] ex;
        bit          exp_ir, exp_ov;
        int          sat_enc, sat_err;
        @(negedge clk);
        exp_ir  = (sb_q.size() < 2) || out_ready;
        exp_ov  = (sb_q.size() > 0) && (cyc >= sb_cyc[0] + 2);
        sat_enc = (exp_enc > 3) ? 3 : exp_enc;
        sat_err = (exp_err > 3) ? 3 : exp_err;
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("enc_count", 32'(enc_count), 32'(exp_enc));
        chk("err_count", 32'(err_count), 32'(exp_err));
        chk("sat_enc_count", 32'(enc_count_s), 32'(sat_enc));
        chk("sat_err_count", 32'(err_count_s), 32'(sat_err));
        chk("sat_in_ready", 32'(in_ready_s), 32'(exp_ir));
        if (hold_prev) chk("hold_instr", out_instr, prev_instr);
        acc_flag   = in_valid && in_ready;
        deliv_flag = out_valid && out_ready;
        if (deliv_flag) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_word", out_instr, 32'h0);
            end else begin
                ex = sb_q.pop_front();
                void'(sb_cyc.pop_front());
                chk("out_instr", out_instr, ex[31:0]);
                chk("out_err", 32'(out_err), 32'(ex[33:32]));
                chk("sat_out_instr", out_instr_s, ex[31:0]);
                if (ex[33:32] == 2'd0) exp_enc++;
                else exp_err++;
            end
            last_instr = out_instr;
            last_err   = out_err;
        end
        if (acc_flag) begin
            sb_q.push_back(model(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
            sb_cyc.push_back(cyc);
        end
        hold_prev  = out_valid && !out_ready;
        prev_instr = out_instr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm);
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    task automatic drain(input string tag);
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            cycle();
            n++;
        end
        if (sb_q.size() > 0) chk({tag, "_drain_timeout"}, 32'(sb_q.size()), 32'd0);
    endtask

    // Send a single request with the output always ready and compare against fixed words.
    task automatic send_one(input string tag, input logic [31:0] exp_w, input logic [1:0] exp_e);
        int n;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!acc_flag && n < 10);
        in_valid = 1'b0;
        n = 0;
        deliv_flag = 1'b0;
        while (!deliv_flag && n < 10) begin
            cycle();
            n++;
        end
        chk({tag, "_delivered"}, 32'(deliv_flag), 32'd1);
        chk({tag, "_instr"}, last_instr, exp_w);
        chk({tag, "_err"}, 32'(last_err), 32'(exp_e));
    endtask

    logic [6:0]  ops[10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h13};
    logic [31:0] bnd[14] = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4096,
                             -32'sd4096, -32'sd4098, 32'h000F_FFFE, 32'h0010_0000,
                             32'hFFF0_0000, 32'd31, 32'd32, 32'hFFFF_F000};

    task automatic rand_req();
        logic [31:0] imm;
        logic [6:0]  op;
        op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
        case ($urandom_range(0, 5))
            0:       imm = 32'($urandom_range(0, 16)) - 32'd8;
            1:       imm = bnd[$urandom_range(0, 13)];
            2:       imm = $urandom;
            3:       imm = $urandom & 32'hFFFF_F000;
            4:       imm = 32'($urandom_range(0, 10000)) - 32'd5000;
            default: imm = 32'($urandom_range(0, 40));
        endcase
        set_req(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                ($urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom), imm);
    endtask

    initial begin
        int idx;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_req(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_enc_count", 32'(enc_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        set_req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        send_one("addi", 32'hFFF0_0093, 2'd0);
        chk("addi_enc_count", 32'(enc_count), 32'd1);
        set_req(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
        send_one("beq", 32'hFE00_0EE3, 2'd0);
        set_req(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd3);
        send_one("beq_odd", 32'h0000_0013, 2'd2);
        chk("beq_odd_err_count", 32'(err_count), 32'd1);
        set_req(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        send_one("jal", 32'h0010_00EF, 2'd0);
        set_req(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        send_one("lui", 32'h1234_52B7, 2'd0);
        set_req(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
        send_one("lui_align", 32'h0000_0013, 2'd2);
        set_req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        send_one("addi_range", 32'h0000_0013, 2'd1);
        set_req(7'b1111111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        send_one("illegal", 32'h0000_0013, 2'd3);
        set_req(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd32);
        send_one("slli_range", 32'h0000_0013, 2'd1);
        set_req(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd3);
        send_one("slli", 32'h0030_9093, 2'd0);

        // Backpressure: three back-to-back requests against a stalled consumer.
        out_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = (idx < 3);
            set_req(7'b0010011, 5'(idx + 2), 5'd3, 5'd0, 3'd0, 7'd0, 32'(idx * 7));
            cycle();
            if (acc_flag) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && idx < 3; i++) begin
            in_valid = 1'b1;
            set_req(7'b0010011, 5'(idx + 2), 5'd3, 5'd0, 3'd0, 7'd0, 32'(idx * 7));
            cycle();
            if (acc_flag) idx++;
        end
        chk("bp_all_accepted", 32'(idx), 32'd3);
        drain("bp");

        for (int i = 0; i < 800; i++) begin
            if (!in_valid || acc_flag) begin
                rand_req();
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain("rand");

        // Reset with two entries in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_req(7'b0010011, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        cycle();
        set_req(7'b0010011, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("mid_in_flight", 32'(sb_q.size()), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_enc_count", 32'(enc_count), 32'd0);
        chk("mid_rst_err_count", 32'(err_count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        sb_q.delete();
        sb_cyc.delete();
        exp_enc   = 0;
        exp_err   = 0;
        hold_prev = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc++;
        set_req(7'b0010011, 5'd9, 5'd2, 5'd0, 3'd0, 7'd0, 32'd100);
        send_one("post_rst", 32'h0641_0493, 2'd0);
        drain("post_rst");
        for (int i = 0; i < 3; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_instr_encoder.md
Name: rv32_instr_encoder

Overview:
- Inverse of the stage-2 immediate extraction: packs opcode, register fields, funct fields and a 32-bit immediate into a legal RV32I instruction word.
- Checks that the immediate is representable in the target format (range and alignment) and flags errors.
- Two-stage valid/ready pipeline with backpressure. Used by the self-test / trampoline generator to emit instructions into instruction memory.

Parameters:
CNT_W, 16, width of the saturating encoded-instruction and error counters

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  encoder can accept request this cycle
in_opcode  input  7  RV32I opcode
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct3  input  3  funct3 field
in_funct7  input  7  funct7 field (R-type; upper bits of shift-immediate)
in_imm  input  32  immediate value as an architectural signed/unsigned number
out_valid  output  1  encoded word valid
out_ready  input  1  consumer accepts word this cycle
out_instr  output  32  encoded instruction
out_err  output  2  0 ok, 1 range, 2 alignment, 3 illegal opcode
enc_count  output  CNT_W  words delivered with out_err==0
err_count  output  CNT_W  words delivered with out_err!=0

Behaviour:
- Reset (async, reset_n=0): both stage valids 0, out_valid=0, out_instr=0, out_err=0, counters 0, in_ready=0 while reset asserted. Any in-flight requests are discarded.
- Handshake: a transfer occurs on a clock edge where valid&ready=1.
  - in_ready = !s1_valid | s1_adv, where s1_adv = !s2_valid | out_ready.
  - Outputs are held stable while out_valid=1 and out_ready=0.
- Latency: 2 cycles from input acceptance to out_valid when not stalled. Full throughput of 1 word per cycle. Two entries are held at most. Order is preserved.
- Stage 1 registers the inputs and decodes the format:
  - R: 0110011
  - I: 0010011, 0000011, 1100111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - Any other opcode is illegal.
- Stage 1 also computes the error code. Priority: illegal opcode > alignment > range.
  - I (non-shift) and S: range error unless in_imm[31:11] is all-equal.
  - I shift (opcode 0010011, funct3 001/101): range error unless in_imm[31:5]==0.
  - B: alignment error if imm[0]=1; range error unless imm[31:12] is all-equal.
  - J: alignment error if imm[0]=1; range error unless imm[31:20] is all-equal.
  - U: alignment error if imm[11:0]!=0.
  - R: immediate ignored, never an error.
- Stage 2 packs the word:
  - R: {funct7,rs2,rs1,f3,rd,op}
  - I: {imm[11:0],rs1,f3,rd,op}
  - I shift: {funct7,imm[4:0],rs1,f3,rd,op}
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
  - U: {imm[31:12],rd,op}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
- On any error, out_instr = 32'h00000013 (NOP) and out_err carries the code.
- Counters: exactly one counter increments per output transfer, selected by out_err. Both saturate at all-ones and never wrap.
- Simultaneous events: with both stages full and out_ready=1, the pipeline shifts and accepts a new input in the same cycle. With out_ready=0 and both stages full, in_ready=0 and nothing moves.

Test Plan:
- ADDI: op 0010011, rd=1, rs1=0, f3=0, imm=32'hFFFFFFFF -> out_instr=32'hFFF00093, out_err=0, out_valid 2 cycles after acceptance, enc_count=1.
- BEQ: op 1100011, rs1=rs2=0, f3=0, imm=-4 -> 32'hFE000EE3. Same request with imm=-3 -> out_err=2, out_instr=32'h00000013, err_count=1.
- JAL: rd=1, imm=32'h800 -> 32'h001000EF. LUI: rd=5, imm=32'h12345000 -> 32'h123452B7. LUI with imm=32'h12345001 -> out_err=2.
- ADDI with imm=2048 -> out_err=1, NOP emitted. Opcode 7'b1111111 -> out_err=3. SLLI f3=001, imm=32 -> out_err=1; imm=3 -> 32'h00309093 for rd=1, rs1=1.
- Backpressure: hold out_ready=0 and offer 3 back-to-back requests -> 2 accepted then in_ready=0. Release out_ready -> all 3 words delivered in order, none lost or duplicated. Counters saturate when preloaded near max in a CNT_W=2 build.
- Reset mid-stream: assert reset_n=0 with 2 entries in flight -> out_valid=0 and counters=0 immediately (asynchronous). After release, the first new request is delivered 2 cycles later with no stale words.
